// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default counter width.
package clk_period_meter_pkg;

  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/clk_period_meter_if.sv
// Control/result bundle of the clock period meter; master is the meter, slave the consumer.
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             valid;
  logic             timeout;
  logic             locked;

  modport master (
    input  en, sig_in,
    output period, high_cnt, valid, timeout, locked
  );

  modport slave (
    output en, sig_in,
    input  period, high_cnt, valid, timeout, locked
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by rise/fall detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in system clock cycles,
// with a sticky timeout when rising edges stop arriving.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 2**CNT_W - 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  clk_period_meter_if.master  bus
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic s, rise, unused_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (bus.sig_in),
    .s       (s),
    .rise    (rise),
    .fall    (unused_fall)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, hcnt, hcnt_n;
  logic [CNT_W-1:0] period_q, period_n, high_q, high_n;
  logic             valid_q, valid_n, timeout_q, timeout_n, locked_q, locked_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      period_q  <= period_n;
      high_q    <= high_n;
      valid_q   <= valid_n;
      timeout_q <= timeout_n;
      locked_q  <= locked_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hcnt_n    = hcnt;
    period_n  = period_q;
    high_n    = high_q;
    valid_n   = 1'b0;
    timeout_n = timeout_q;
    locked_n  = locked_q;

    if (!bus.en) begin
      state_n   = IDLE;
      cnt_n     = '0;
      hcnt_n    = '0;
      locked_n  = 1'b0;
      timeout_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n   = '0;
          hcnt_n  = '0;
          state_n = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_n   = ONE;
            hcnt_n  = ONE;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still closes a valid period.
          if (rise) begin
            period_n  = cnt;
            high_n    = hcnt;
            valid_n   = 1'b1;
            locked_n  = 1'b1;
            timeout_n = 1'b0;
            cnt_n     = ONE;
            hcnt_n    = ONE;
          end else if (cnt == TO_VAL) begin
            timeout_n = 1'b1;
            locked_n  = 1'b0;
            cnt_n     = '0;
            hcnt_n    = '0;
            state_n   = ARM;
          end else begin
            cnt_n = cnt + ONE;
            if (s) hcnt_n = hcnt + ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.period   = period_q;
  assign bus.high_cnt = high_q;
  assign bus.valid    = valid_q;
  assign bus.timeout  = timeout_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed/randomized bench for clk_period_meter: expectations come from the driven edge times.
module tb_clk_period_meter;

  localparam int CNT_W   = 16;
  localparam int TO_CYC  = 100;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_per = 0;
  int   last_hi = 0;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int lk;
    int to;
  } vrec_t;

  vrec_t cap[$];

  clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO_CYC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1)
      cap.push_back('{cyc, int'(bus.period), int'(bus.high_cnt), int'(bus.locked), int'(bus.timeout)});
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n full periods plus a closing rise; each period's edges are recorded and the
  // expected valids (from the second rise on) are derived from those edge times.
  task automatic run_train(input string tag, input int n, input int hmin, input int hmax,
                           input int lmin, input int lmax, output int last_rise);
    int r[$];
    int hq[$];
    int h, l;
    cap.delete();
    for (int i = 0; i <= n; i++) begin
      h = (i < n) ? int'($urandom_range(hmax, hmin)) : 2;
      l = int'($urandom_range(lmax, lmin));
      r.push_back(cyc);
      hq.push_back(h);
      bus.sig_in = 1'b1;
      repeat (h) step();
      if (i < n) begin
        bus.sig_in = 1'b0;
        repeat (l) step();
      end
    end
    bus.sig_in = 1'b0;
    repeat (8) step();
    last_rise = r[n];
    chk({tag, "_nvalid"}, cap.size(), n);
    for (int i = 1; i <= n; i++) begin
      if (i - 1 < cap.size()) begin
        chk({tag, "_vcyc"}, cap[i-1].cyc, r[i] + LAT);
        chk({tag, "_period"}, cap[i-1].per, r[i] - r[i-1]);
        chk({tag, "_high"}, cap[i-1].hi, hq[i-1]);
        chk({tag, "_locked"}, cap[i-1].lk, 1);
        chk({tag, "_timeout"}, cap[i-1].to, 0);
      end
    end
    if (n > 0) begin
      last_per = r[n] - r[n-1];
      last_hi  = hq[n-1];
    end
  endtask

  task automatic en_drop(input string tag);
    cap.delete();
    bus.en = 1'b0;
    step();
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_period_hold"}, int'(bus.period), last_per);
    chk({tag, "_high_hold"}, int'(bus.high_cnt), last_hi);
    repeat (3) step();
    chk({tag, "_period_hold2"}, int'(bus.period), last_per);
    chk({tag, "_novalid"}, cap.size(), 0);
    bus.en = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int lr;
    int guard;
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_period", int'(bus.period), 0);
    chk("rst_high", int'(bus.high_cnt), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_locked", int'(bus.locked), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    bus.en = 1'b1;
    repeat (3) step();

    run_train("sym32", 3, 32, 32, 32, 32, lr);
    en_drop("drop1");

    run_train("asym3_7", 5, 3, 3, 7, 7, lr);
    en_drop("drop2");

    run_train("rand", 8, 1, 40, 1, 40, lr);
    en_drop("drop3");

    run_train("toggle", 6, 1, 1, 1, 1, lr);

    // Timeout: one rise after arming, then the line stays low.
    en_drop("drop4");
    run_train("single", 0, 1, 1, 1, 1, lr);
    guard = 0;
    @(negedge clk);
    while (cyc < lr + LAT + TO_CYC - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("to_guard", int'(guard < 1000), 1);
    chk("to_before", int'(bus.timeout), 0);
    @(negedge clk);
    chk("to_cycle", cyc, lr + LAT + TO_CYC);
    chk("to_set", int'(bus.timeout), 1);
    chk("to_locked", int'(bus.locked), 0);
    chk("to_novalid", cap.size(), 0);
    step();
    chk("to_sticky", int'(bus.timeout), 1);
    run_train("resume20", 3, 10, 10, 10, 10, lr);

    // Reset while measuring with the input still toggling.
    repeat (5) begin
      bus.sig_in = ~bus.sig_in;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_period", int'(bus.period), 0);
    chk("mrst_high", int'(bus.high_cnt), 0);
    chk("mrst_valid", int'(bus.valid), 0);
    chk("mrst_locked", int'(bus.locked), 0);
    chk("mrst_timeout", int'(bus.timeout), 0);
    bus.sig_in = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    run_train("postrst", 2, 1, 20, 1, 20, lr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
